// File: rtl/sap_defs_pkg.sv
// sap_defs: shared opcodes, control-bit indices and control-word helpers for the SAP machine
// Contents: OP_* opcode constants, CB_* bit positions of the control word, CTRL_W, cb() one-hot helper
package sap_defs;
  localparam int CTRL_W = 12;
  localparam int OP_W = 4;
  typedef logic [CTRL_W-1:0] ctrl_t;
  localparam logic [OP_W-1:0] OP_LDA = 4'h0;
  localparam logic [OP_W-1:0] OP_ADD = 4'h1;
  localparam logic [OP_W-1:0] OP_SUB = 4'h2;
  localparam logic [OP_W-1:0] OP_OUT = 4'he;
  localparam logic [OP_W-1:0] OP_HLT = 4'hf;
  localparam int CB_CP = 11;
  localparam int CB_EP = 10;
  localparam int CB_LM = 9;
  localparam int CB_CE = 8;
  localparam int CB_LI = 7;
  localparam int CB_EI = 6;
  localparam int CB_LA = 5;
  localparam int CB_EA = 4;
  localparam int CB_SU = 3;
  localparam int CB_EU = 2;
  localparam int CB_LB = 1;
  localparam int CB_LO = 0;
  function automatic ctrl_t cb(input int i);
    return ctrl_t'(1) << i;
  endfunction
endpackage

// File: rtl/sap_ring_counter.sv
// sap_ring_counter: one-hot rotating T-state ring
// Ports: clk, clr (sync active-low, resets to bit0), i_hold (freeze), o_state (one-hot ring)
module sap_ring_counter #(
  parameter int N = 6
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         i_hold,
  output logic [N-1:0] o_state
);
  always_ff @(posedge clk)
    if (!clr) o_state <= {{(N-1){1'b0}}, 1'b1};
    else if (!i_hold) o_state <= {o_state[N-2:0], o_state[N-1]};
endmodule

// File: rtl/sap_controller.sv
// sap_controller: SAP controller-sequencer decoding T-state ring and opcode into the control word
// Ports: clk, clr (sync active-low), i_opcode (IR upper nibble), o_ctrl (control word),
//        o_t_state (one-hot ring, bit0 = T1), o_halt (HLT decoded or latched)
module sap_controller #(
  parameter int OP_W = 4,
  parameter int CTRL_W = 12
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [OP_W-1:0]   i_opcode,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [5:0]        o_t_state,
  output logic              o_halt
);
  import sap_defs::*;
  logic halted;
  logic hlt_now;
  logic is_lda, is_alu, is_out;
  ctrl_t t4, t5, t6, dec;
  assign hlt_now = o_t_state[3] & (i_opcode == OP_HLT);
  sap_ring_counter #(.N(6)) u_ring (
    .clk(clk),
    .clr(clr),
    .i_hold(halted | hlt_now),
    .o_state(o_t_state)
  );
  always_ff @(posedge clk)
    if (!clr) halted <= 1'b0;
    else if (hlt_now) halted <= 1'b1;
  always_comb begin
    is_lda = i_opcode == OP_LDA;
    is_alu = (i_opcode == OP_ADD) | (i_opcode == OP_SUB);
    is_out = i_opcode == OP_OUT;
    t4 = is_out ? cb(CB_EA) | cb(CB_LO) : (is_lda | is_alu) ? cb(CB_EI) | cb(CB_LM) : '0;
    t5 = is_lda ? cb(CB_CE) | cb(CB_LA) : is_alu ? cb(CB_CE) | cb(CB_LB) : '0;
    t6 = !is_alu ? '0 : (i_opcode == OP_SUB) ? cb(CB_LA) | cb(CB_EU) | cb(CB_SU) : cb(CB_LA) | cb(CB_EU);
    dec = o_t_state[0] ? cb(CB_EP) | cb(CB_LM) :
          o_t_state[1] ? cb(CB_CP) :
          o_t_state[2] ? cb(CB_CE) | cb(CB_LI) :
          o_t_state[3] ? t4 :
          o_t_state[4] ? t5 :
          o_t_state[5] ? t6 : '0;
  end
  assign o_ctrl = (clr && !halted) ? dec : '0;
  assign o_halt = clr & (halted | hlt_now);
endmodule

// File: tb/tb_sap_controller.sv
// tb_sap_controller: randomized self-checking bench for sap_controller against an instruction-level model
module tb_sap_controller;
  logic clk = 1'b0;
  logic clr = 1'b0;
  logic [3:0] i_opcode = 4'h0;
  logic [11:0] o_ctrl;
  logic [5:0] o_t_state;
  logic o_halt;
  int tests = 0;
  int fails = 0;
  int step = 0;
  bit halted = 1'b0;
  always #5 clk = ~clk;
  sap_controller dut (
    .clk(clk),
    .clr(clr),
    .i_opcode(i_opcode),
    .o_ctrl(o_ctrl),
    .o_t_state(o_t_state),
    .o_halt(o_halt)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (step %0d t=%0t)", tag, got, exp, step, $time);
    end
  endtask
  function automatic logic [11:0] ref_ctrl(input int s, input logic [3:0] op);
    case (s)
      0: return 12'h600;
      1: return 12'h800;
      2: return 12'h180;
      3: return (op == 4'h0 || op == 4'h1 || op == 4'h2) ? 12'h240 : (op == 4'he) ? 12'h011 : 12'h000;
      4: return (op == 4'h0) ? 12'h120 : (op == 4'h1 || op == 4'h2) ? 12'h102 : 12'h000;
      5: return (op == 4'h1) ? 12'h024 : (op == 4'h2) ? 12'h02c : 12'h000;
      default: return 12'h000;
    endcase
  endfunction
  task automatic cycle(input logic c, input logic [3:0] op);
    clr = c;
    i_opcode = op;
    @(negedge clk);
    check("ctrl", o_ctrl, (c && !halted) ? ref_ctrl(step, op) : 12'h000);
    check("t_state", o_t_state, 32'(1) << step);
    check("halt", o_halt, c && (halted || (step == 3 && op == 4'hf)));
    check("bus_drive", $countones({o_ctrl[10], o_ctrl[8], o_ctrl[6], o_ctrl[4], o_ctrl[2]}) <= 1, 1);
    @(posedge clk);
    if (!c) begin
      step = 0;
      halted = 1'b0;
    end else if (!halted) begin
      if (step == 3 && op == 4'hf) halted = 1'b1;
      else step = (step + 1) % 6;
    end
    #1;
  endtask
  task automatic run_instr(input logic [3:0] op, input int abort_at);
    int k = 0;
    do begin
      cycle(k != abort_at, (step < 3) ? 4'($urandom) : op);
      k++;
    end while (step != 0 && k < 12);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [3:0] ops [6] = '{4'h0, 4'h1, 4'h2, 4'he, 4'hf, 4'h5};
    clr = 1'b0;
    @(posedge clk);
    #1;
    cycle(1'b0, 4'h3);
    run_instr(4'h0, -1);
    run_instr(4'h1, -1);
    run_instr(4'h2, -1);
    run_instr(4'he, -1);
    run_instr(4'h5, -1);
    run_instr(4'hf, -1);
    repeat (4) cycle(1'b1, 4'($urandom));
    cycle(1'b0, 4'h0);
    run_instr(4'h1, 4);
    run_instr(4'h0, -1);
    for (int n = 0; n < 300; n++) begin
      logic [3:0] op;
      op = ($urandom % 4 == 0) ? 4'($urandom) : ops[$urandom % 6];
      run_instr(op, ($urandom % 8 == 0) ? int'($urandom % 6) : -1);
      if (halted) begin
        repeat ($urandom % 5) cycle(1'b1, 4'($urandom));
        cycle(1'b0, 4'($urandom));
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sap_controller.md
Name: sap_controller

Overview:
- Controller-sequencer for the SAP datapath.
- Generates a 6-state one-hot T-state ring and decodes it with the IR opcode into the per-register load enables and bus-drive enables.
- It sits directly upstream of every datapath register (PC, MAR, IR, A, B, OUT). Its load-enable bits drive those registers' i_en inputs.
- Registers load on the posedge that ends the cycle in which their enable is high.

Parameters:
- OP_W, 4, opcode width; upper nibble of IR.
- CTRL_W, 12, control word width. Fixed by the bit map; overriding it is illegal.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- clr  input  1  synchronous active-low reset, sampled on posedge clk.
- i_opcode  input  OP_W  IR opcode. Valid from T4 onward.
- o_ctrl  output  CTRL_W  control word.
  - Bit map: [11] Cp PC increment, [10] Ep PC drive, [9] Lm MAR load, [8] CE RAM drive, [7] Li IR load, [6] Ei IR operand drive, [5] La A load, [4] Ea A drive, [3] Su ALU subtract, [2] Eu ALU drive, [1] Lb B load, [0] Lo OUT load.
  - All bits are active-high.
- o_t_state  output  6  one-hot ring state; bit0 = T1.
- o_halt  output  1  high when HLT has been decoded; used to gate the system clock externally.

Behaviour:
- Reset:
  - clr==0 at posedge: ring = T1 (6'b000001) and halted flag = 0.
  - While clr==0, o_ctrl and o_halt are forced to 0 combinationally.
  - Reset applied mid-instruction aborts it; the first cycle after release is T1.
- Ring:
  - When not halted, it rotates one position per posedge: T1->T2->...->T6->T1.
  - Exactly one bit of o_t_state is ever set.
- o_ctrl is a combinational decode of ring state, i_opcode and the halted flag. There are no registered outputs.
- Fetch (opcode ignored):
  - T1 = 0x600 (Ep, Lm).
  - T2 = 0x800 (Cp).
  - T3 = 0x180 (CE, Li).
- Execute, T4/T5/T6:
  - LDA 0000: 0x240 / 0x120 / 0x000.
  - ADD 0001: 0x240 / 0x102 / 0x024.
  - SUB 0010: 0x240 / 0x102 / 0x02C.
  - OUT 1110: 0x011 / 0x000 / 0x000.
  - Any other non-HLT opcode: NOP, 0x000 in T4–T6.
- HLT 1111:
  - In T4, o_ctrl=0x000 and o_halt=1 combinationally.
  - At the next posedge the halted flag is set and the ring freezes at T4.
  - From then on o_halt=1 and o_ctrl=0 until clr==0.
- Latency: one instruction = 6 clocks. Control for Tn is visible for the whole cycle Tn, and its loads take effect at the posedge ending Tn.
- Opcode changes during T1–T3 have no effect on o_ctrl.
- No bus contention: at most one drive bit (Ep, CE, Ei, Ea, Eu) is high in any cycle. The bench checks this as an assertion.

Decomposition:
- Shared header/package sap_defs:
  - opcode constants OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT;
  - control-bit index constants CB_CP..CB_LO;
  - CTRL_W.
  - The datapath top reuses the index constants when wiring i_en.
- One sub-module, sap_ring_counter:
  - parameter N=6;
  - ports clk, clr, i_hold, o_state;
  - one-hot rotate, synchronous active-low reset to bit0, holds when i_hold=1.
- The decoder stays in sap_controller.

Test Plan:
- Reset: hold clr=0 for 2 posedges, then release -> o_t_state=6'b000001 and o_ctrl=0x000 during reset; first cycle after release o_ctrl=0x600; over 6 clocks the state sequence is 01,02,04,08,10,20 and then wraps to 01.
- LDA: i_opcode=0000 -> per-cycle o_ctrl T1..T6 = 600,800,180,240,120,000.
- ADD then SUB: two consecutive instructions -> T6 = 0x024, then T6 = 0x02C; T4/T5 = 0x240/0x102 in both.
- OUT and undefined opcode: 1110 -> T4=0x011, T5=T6=0x000; opcode 0101 -> T4–T6 all 0x000. Change i_opcode during T1–T3 -> fetch words unchanged.
- HLT: 1111 at T4 -> o_halt=1 in T4, ring stays 6'b001000 for 10 further clocks, o_ctrl=0x000 throughout. Then clr=0 for one posedge -> o_halt=0 and T1 resumes.
- Mid-instruction reset: clr=0 during T5 of an ADD -> next cycle is T1 with o_ctrl=0x600, and 0x024 never appears for the aborted instruction.
